axis_trigger_window: RTL and testbench
======================================

# axis_trigger_window

Parametrised AXI4-Stream trigger-window capture block. It sits between a streaming ADC/data source and the DMA S2MM stream port. After a software start it forwards a prebuffer, waits for a qualified trigger, and forwards a fixed number of post-trigger beats. It then injects tlast and either re-arms for the next segment or returns to idle. Versus the previous generation it adds:
- generic data, trigger and counter widths;
- per-bit level/edge and polarity selection;
- multi-segment acquisitions, software force-trigger and abort;
- true backpressure passthrough;
- trigger position reporting.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width
- TRIG_WIDTH, 32, trigger input bits
- COUNT_WIDTH, 32, width of beat counters and beat-count registers
- SEG_WIDTH, 16, width of segment count
- CDC_STAGES, 2, synchroniser depth for start/abort/force/idle (≥2)

Ports:
- stream_clk  in  1  sole clock
- stream_resetn  in  1  reset, asynchronous, active-low
- trigger  in  TRIG_WIDTH  trigger bits, aligned to s_tdata beat
- trigger_enable_i / trigger_invert_i / trigger_edge_i  in  TRIG_WIDTH each  mask; polarity (1=active low); mode (1=rising edge, 0=level). Quasi-static, changed only while idle.
- prebuffer_beats_i  in  COUNT_WIDTH  beats forwarded before trigger is armed
- post_trigger_beats_i  in  COUNT_WIDTH  beats after trigger beat; tlast beat = trigger beat + this value
- segments_i  in  SEG_WIDTH  segments per start; 0 treated as 1
- start_i, abort_i, force_trigger_i  in  1 each  software controls, synchronised internally
- idle_o  out  1  synchronised idle status
- trigger_detected_o  out  TRIG_WIDTH  qualified hit vector of last trigger (0 for forced)
- trigger_beat_o  out  COUNT_WIDTH  in-segment index of last trigger beat
- segments_done_o  out  SEG_WIDTH  completed segments since last start
- s_tdata/s_tvalid/s_tready, m_tdata/m_tvalid/m_tready/m_tlast  standard AXI4-Stream, DATA_WIDTH data
- dbg_state  out  3  current state encoding

## Operation
- States: IDLE, PREBUFFER, AWAIT, POST, FLUSH.
- Accepted beat ("beat") = s_tvalid & s_tready.
- IDLE:
  - s_tready=1, input discarded, m_tvalid=0.
  - Rising edge of synchronised start → clears segments_done_o; goes to PREBUFFER, or to AWAIT if prebuffer_beats_i=0.
- Active states:
  - m_tvalid=s_tvalid, m_tdata=s_tdata, s_tready=m_tready. Combinational, zero latency.
- beat_idx:
  - Zeroed on segment entry; +1 per beat; saturates at all-ones.
- PREBUFFER:
  - pre_cnt counts beats; on the beat making pre_cnt=prebuffer_beats_i → AWAIT.
  - Triggers are ignored.
- Trigger qualification, per bit on each beat in any state:
  - lvl = trigger^invert;
  - hit = enable & (edge ? lvl & ~prev_lvl : lvl).
  - prev_lvl updates only on beats and resets to 0.
- AWAIT, trigger on a beat with |hit, or on a force pulse (synchronised rising edge, latched until the next AWAIT beat):
  - that beat is the trigger beat;
  - latch trigger_detected_o=hit (0 if forced only) and trigger_beat_o=beat_idx;
  - if post_trigger_beats_i=0, m_tlast=1 on this beat and the segment ends; else → POST with post_cnt=0.
- POST:
  - post_cnt +1 per beat;
  - m_tlast = (post_cnt+1 == post_trigger_beats_i) on the beat; that beat ends the segment.
- Segment end:
  - segments_done_o +1;
  - if segments_done_o+1 < max(segments_i,1), re-enter PREBUFFER/AWAIT as from start; else IDLE.
- Abort (synchronised level) in PREBUFFER/AWAIT/POST → FLUSH.
  - FLUSH: next beat carries m_tlast=1, then IDLE; segments_done_o not incremented.
  - Abort in IDLE ignored; start in active states ignored.
- Simultaneous events:
  - abort and trigger in the same cycle: abort wins, and trigger_detected_o is still latched.
  - A post-count tlast beat coinciding with abort ends normally.

## Timing
- Async reset values:
  - state IDLE; all counters 0; m_tvalid=0, m_tlast=0, s_tready=1;
  - trigger_detected_o=0, trigger_beat_o=0, segments_done_o=0;
  - sync flops 0 except the idle chain, which is 1, so idle_o=1.
- Reset mid-operation: stream ends without tlast; downstream DMA must be reset too.
- Control latency:
  - start/abort/force take effect CDC_STAGES+1 cycles after the input edge.
  - idle_o lags state by CDC_STAGES cycles.
- No beat is lost or duplicated under m_tready backpressure; tlast stalls with its beat.

## Structure
- Package axis_trigger_pkg: state localparams (IDLE=0, PREBUFFER=1, AWAIT=2, POST=3, FLUSH=4) and the state width constant.
- Sub-module trigger_qualifier: enable/invert/edge logic and prev_lvl register, parametrised by TRIG_WIDTH, with a beat strobe input.
- Reuse the existing register and counter primitives for the state, counters and status registers.

## Test plan
- pre=4, post=3, segments=1, level trigger bit 0 asserted on beat 6 → 4+3+3 beats forwarded, tlast on beat 9, trigger_beat_o=6, trigger_detected_o=1, idle_o returns.
- Edge mode, bit 5 held high through prebuffer then low→high at beat 10 → trigger at beat 10 only; a level-high trigger held from the start does not fire in edge mode.
- post=0 with random m_tready backpressure (50%) → tlast on the trigger beat itself; data sequence equals input with no gaps or duplicates.
- segments=3, pre=2, post=2, triggers each segment → three tlast-terminated packets, segments_done_o=3, then IDLE.
- force_trigger pulse in AWAIT with no hits → trigger_detected_o=0, tlast 5 beats later for post=5.
- abort during POST → next beat has tlast, state IDLE, segments_done_o unchanged; async reset asserted mid-PREBUFFER → m_tvalid=0 immediately, idle_o=1.

Source files
------------

// File: rtl/axis_trigger_pkg.sv
// axis_trigger_pkg: state encoding shared by the trigger-window capture block
package axis_trigger_pkg;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] PREBUFFER = 3'd1;
  localparam logic [STATE_W-1:0] AWAIT     = 3'd2;
  localparam logic [STATE_W-1:0] POST      = 3'd3;
  localparam logic [STATE_W-1:0] FLUSH     = 3'd4;
endpackage

// File: rtl/axis_trigger_window_qualifier.sv
// trigger_qualifier: per-bit polarity, level/edge selection and enable gating of trigger inputs
module trigger_qualifier #(
  parameter int TRIG_WIDTH = 32
) (
  input  logic                  stream_clk,
  input  logic                  stream_resetn,
  input  logic                  beat,
  input  logic [TRIG_WIDTH-1:0] trigger,
  input  logic [TRIG_WIDTH-1:0] enable,
  input  logic [TRIG_WIDTH-1:0] invert,
  input  logic [TRIG_WIDTH-1:0] edge_sel,
  output logic [TRIG_WIDTH-1:0] hit
);
  logic [TRIG_WIDTH-1:0] lvl, prev_lvl;
  always_comb begin
    lvl = trigger ^ invert;
    hit = enable & ((edge_sel & lvl & ~prev_lvl) | (~edge_sel & lvl));
  end
  // history only advances on accepted beats so stalls never fake an edge
  always_ff @(posedge stream_clk or negedge stream_resetn)
    if (!stream_resetn) prev_lvl <= '0;
    else prev_lvl <= beat ? lvl : prev_lvl;
endmodule

// File: rtl/axis_trigger_window.sv
// axis_trigger_window: AXI4-Stream prebuffer / trigger / post-trigger segment capture with tlast injection
module axis_trigger_window
  import axis_trigger_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TRIG_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int SEG_WIDTH   = 16,
  parameter int CDC_STAGES  = 2
) (
  input  logic                   stream_clk,
  input  logic                   stream_resetn,
  input  logic [TRIG_WIDTH-1:0]  trigger,
  input  logic [TRIG_WIDTH-1:0]  trigger_enable_i,
  input  logic [TRIG_WIDTH-1:0]  trigger_invert_i,
  input  logic [TRIG_WIDTH-1:0]  trigger_edge_i,
  input  logic [COUNT_WIDTH-1:0] prebuffer_beats_i,
  input  logic [COUNT_WIDTH-1:0] post_trigger_beats_i,
  input  logic [SEG_WIDTH-1:0]   segments_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   force_trigger_i,
  output logic                   idle_o,
  output logic [TRIG_WIDTH-1:0]  trigger_detected_o,
  output logic [COUNT_WIDTH-1:0] trigger_beat_o,
  output logic [SEG_WIDTH-1:0]   segments_done_o,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [2:0]             dbg_state
);
  logic [STATE_W-1:0] state, state_nx, entry_state;
  logic [CDC_STAGES-1:0] start_sync, abort_sync, force_sync, idle_sync;
  logic start_prev, force_prev, force_pend;
  logic start_rise, force_rise, abort_lvl;
  logic [COUNT_WIDTH-1:0] beat_idx, pre_cnt, post_cnt;
  logic [TRIG_WIDTH-1:0] hit;
  logic [SEG_WIDTH-1:0] seg_target;
  logic [SEG_WIDTH:0] done_nx;
  logic beat, trig, post_zero, pre_last, post_last, seg_end, rearm, seg_entry;

  trigger_qualifier #(.TRIG_WIDTH(TRIG_WIDTH)) u_qual (
    .stream_clk   (stream_clk),
    .stream_resetn(stream_resetn),
    .beat         (beat),
    .trigger      (trigger),
    .enable       (trigger_enable_i),
    .invert       (trigger_invert_i),
    .edge_sel     (trigger_edge_i),
    .hit          (hit)
  );

  // idle chain resets to 1 so idle_o reads idle straight out of reset
  always_ff @(posedge stream_clk or negedge stream_resetn)
    if (!stream_resetn) begin
      start_sync <= '0;
      abort_sync <= '0;
      force_sync <= '0;
      idle_sync  <= '1;
      start_prev <= 1'b0;
      force_prev <= 1'b0;
    end else begin
      start_sync <= {start_sync[CDC_STAGES-2:0], start_i};
      abort_sync <= {abort_sync[CDC_STAGES-2:0], abort_i};
      force_sync <= {force_sync[CDC_STAGES-2:0], force_trigger_i};
      idle_sync  <= {idle_sync[CDC_STAGES-2:0], state == IDLE};
      start_prev <= start_sync[CDC_STAGES-1];
      force_prev <= force_sync[CDC_STAGES-1];
    end

  always_comb begin
    start_rise  = start_sync[CDC_STAGES-1] & ~start_prev;
    force_rise  = force_sync[CDC_STAGES-1] & ~force_prev;
    abort_lvl   = abort_sync[CDC_STAGES-1];
    idle_o      = idle_sync[CDC_STAGES-1];
    beat        = s_tvalid & s_tready;
    post_zero   = post_trigger_beats_i == '0;
    trig        = (state == AWAIT) & s_tvalid & ((|hit) | force_pend | force_rise);
    pre_last    = (state == PREBUFFER) & (pre_cnt + COUNT_WIDTH'(1) == prebuffer_beats_i);
    post_last   = (state == POST) & (post_cnt + COUNT_WIDTH'(1) == post_trigger_beats_i);
    seg_end     = beat & ((trig & post_zero & ~abort_lvl) | post_last);
    seg_target  = segments_i == '0 ? SEG_WIDTH'(1) : segments_i;
    done_nx     = {1'b0, segments_done_o} + (SEG_WIDTH+1)'(1);
    rearm       = done_nx < {1'b0, seg_target};
    entry_state = prebuffer_beats_i == '0 ? AWAIT : PREBUFFER;
    seg_entry   = ((state == IDLE) & start_rise) | (seg_end & rearm);
  end

  always_ff @(posedge stream_clk or negedge stream_resetn)
    if (!stream_resetn) state <= IDLE;
    else state <= state_nx;

  // a completing post-count beat outranks abort; abort outranks everything else
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start_rise ? entry_state : IDLE;
    else if (state == FLUSH) state_nx = beat ? IDLE : FLUSH;
    else if (state > FLUSH) state_nx = IDLE;
    else if (seg_end) state_nx = rearm ? entry_state : IDLE;
    else if (abort_lvl) state_nx = FLUSH;
    else if (beat & pre_last) state_nx = AWAIT;
    else if (beat & trig) state_nx = POST;
  end

  always_comb begin
    s_tready  = state == IDLE ? 1'b1 : m_tready;
    m_tvalid  = (state != IDLE) & s_tvalid;
    m_tdata   = s_tdata;
    m_tlast   = (state == FLUSH) | post_last | (trig & post_zero & ~abort_lvl);
    dbg_state = state;
  end

  always_ff @(posedge stream_clk or negedge stream_resetn)
    if (!stream_resetn) begin
      beat_idx           <= '0;
      pre_cnt            <= '0;
      post_cnt           <= '0;
      force_pend         <= 1'b0;
      trigger_detected_o <= '0;
      trigger_beat_o     <= '0;
      segments_done_o    <= '0;
    end else begin
      beat_idx   <= seg_entry ? '0 : beat & ~&beat_idx ? beat_idx + COUNT_WIDTH'(1) : beat_idx;
      pre_cnt    <= seg_entry ? '0 : beat & (state == PREBUFFER) ? pre_cnt + COUNT_WIDTH'(1) : pre_cnt;
      post_cnt   <= seg_entry ? '0 : beat & (state == POST) ? post_cnt + COUNT_WIDTH'(1) : post_cnt;
      force_pend <= (state == IDLE) | (beat & (state == AWAIT)) ? 1'b0 : force_pend | force_rise;
      trigger_detected_o <= beat & trig ? hit : trigger_detected_o;
      trigger_beat_o     <= beat & trig ? beat_idx : trigger_beat_o;
      segments_done_o    <= (state == IDLE) & start_rise ? '0 : seg_end ? done_nx[SEG_WIDTH-1:0] : segments_done_o;
    end
endmodule

// File: tb/tb_axis_trigger_window.sv
// tb_axis_trigger_window: table-driven scenarios, corner sequences and a randomized beat-level reference model
module tb_axis_trigger_window;
  localparam int DW = 32, TW = 32, CW = 32, SW = 16;

  logic stream_clk = 1'b0, stream_resetn = 1'b0;
  logic [TW-1:0] trigger = '0, trigger_enable_i = '0, trigger_invert_i = '0, trigger_edge_i = '0;
  logic [CW-1:0] prebuffer_beats_i = '0, post_trigger_beats_i = '0;
  logic [SW-1:0] segments_i = '0;
  logic start_i = 1'b0, abort_i = 1'b0, force_trigger_i = 1'b0;
  logic idle_o;
  logic [TW-1:0] trigger_detected_o;
  logic [CW-1:0] trigger_beat_o;
  logic [SW-1:0] segments_done_o;
  logic [DW-1:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 1'b0, s_tready, m_tvalid, m_tready = 1'b1, m_tlast;
  logic [2:0] dbg_state;
  int n_pass = 0, n_total = 0;

  typedef struct {
    int pre; int post; int segs;
    logic [31:0] en; logic [31:0] inv; logic [31:0] edg;
    int early_hi; int trig_at; bit bp;
    int exp_last; int exp_tbeat; logic [31:0] exp_det; int exp_segs;
  } vec_t;
  vec_t tbl[6];

  axis_trigger_window dut (
    .stream_clk(stream_clk), .stream_resetn(stream_resetn), .trigger(trigger),
    .trigger_enable_i(trigger_enable_i), .trigger_invert_i(trigger_invert_i), .trigger_edge_i(trigger_edge_i),
    .prebuffer_beats_i(prebuffer_beats_i), .post_trigger_beats_i(post_trigger_beats_i), .segments_i(segments_i),
    .start_i(start_i), .abort_i(abort_i), .force_trigger_i(force_trigger_i), .idle_o(idle_o),
    .trigger_detected_o(trigger_detected_o), .trigger_beat_o(trigger_beat_o), .segments_done_o(segments_done_o),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .dbg_state(dbg_state)
  );

  always #5 stream_clk = ~stream_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge stream_clk);
    #1;
  endtask

  task automatic wait_idle(input logic v);
    int c = 0;
    while (idle_o !== v && c < 30) begin
      tick();
      c++;
    end
    chk(v ? "idle_return" : "idle_leave", idle_o, v);
  endtask

  task automatic configure(input int pre, input int post, input int segs,
                           input logic [31:0] en, input logic [31:0] inv, input logic [31:0] edg);
    prebuffer_beats_i = pre;
    post_trigger_beats_i = post;
    segments_i = SW'(segs);
    trigger_enable_i = en;
    trigger_invert_i = inv;
    trigger_edge_i = edg;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    repeat (4) tick();
    start_i = 1'b0;
    wait_idle(1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int k, c;
    configure(v.pre, v.post, v.segs, v.en, v.inv, v.edg);
    do_start();
    for (int s = 0; s < (v.segs == 0 ? 1 : v.segs); s++) begin
      k = 0;
      c = 0;
      while (k <= v.exp_last && c < 200) begin
        s_tvalid = 1'b1;
        s_tdata = 32'hA500_0000 | (s << 8) | k;
        trigger = ((k < v.early_hi || k >= v.trig_at) ? v.en : 32'h0) ^ v.inv;
        m_tready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("vec_beat", {m_tvalid, m_tlast, s_tready, m_tdata}, {1'b1, k == v.exp_last, m_tready, s_tdata});
        @(posedge stream_clk);
        #1;
        if (m_tready) k++;
        c++;
      end
      chk("vec_seg_len", k, v.exp_last + 1);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_idle(1'b1);
    chk("vec_trigger_beat", trigger_beat_o, v.exp_tbeat);
    chk("vec_trigger_detected", trigger_detected_o, v.exp_det);
    chk("vec_segments_done", segments_done_o, v.exp_segs);
    chk("vec_state_idle", dbg_state, 0);
  endtask

  // beat-level reference: positions within a segment decide prebuffer, trigger and tlast
  logic [31:0] m_prev, r_en, r_inv, r_edg, lvl, hit, exp_det, d, t;
  int r_pre, r_post, r_segs, nseg, seg, idx, tat, ntat, exp_tb, c;
  logic v, rdy, last, fresh;

  initial begin
    tbl[0] = '{4, 3, 1, 32'h1,  32'h0, 32'h0,  0, 6,  1'b0, 9,  6,  32'h1,  1};
    tbl[1] = '{3, 0, 1, 32'h2,  32'h0, 32'h0,  0, 5,  1'b1, 5,  5,  32'h2,  1};
    tbl[2] = '{2, 2, 3, 32'h1,  32'h0, 32'h0,  0, 3,  1'b0, 5,  3,  32'h1,  3};
    tbl[3] = '{1, 1, 1, 32'h8,  32'h8, 32'h0,  0, 4,  1'b0, 5,  4,  32'h8,  1};
    tbl[4] = '{0, 1, 0, 32'h1,  32'h0, 32'h0,  0, 2,  1'b1, 3,  2,  32'h1,  1};
    tbl[5] = '{4, 2, 1, 32'h20, 32'h0, 32'h20, 4, 10, 1'b0, 12, 10, 32'h20, 1};

    repeat (3) tick();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_idle", idle_o, 1);
    chk("rst_detected", trigger_detected_o, 0);
    chk("rst_trigger_beat", trigger_beat_o, 0);
    chk("rst_segments", segments_done_o, 0);
    chk("rst_state", dbg_state, 0);
    stream_resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // edge mode with bit 5 already high: no fire until a force pulse
    configure(0, 5, 1, 32'h20, 32'h0, 32'h20);
    trigger = 32'h20;
    do_start();
    for (int k = 0; k < 12; k++) begin
      if (k == 6) begin
        chk("force_await_state", dbg_state, 2);
        s_tvalid = 1'b0;
        force_trigger_i = 1'b1;
        repeat (4) tick();
        force_trigger_i = 1'b0;
        repeat (4) tick();
      end
      s_tvalid = 1'b1;
      s_tdata = 32'hF000_0000 | k;
      #1;
      chk("force_beat", {m_tvalid, m_tlast}, {1'b1, k == 11});
      tick();
    end
    s_tvalid = 1'b0;
    wait_idle(1'b1);
    chk("force_detected", trigger_detected_o, 0);
    chk("force_trigger_beat", trigger_beat_o, 6);

    // abort while in POST
    configure(1, 10, 1, 32'h1, 32'h0, 32'h0);
    do_start();
    for (int k = 0; k < 5; k++) begin
      s_tvalid = 1'b1;
      trigger = k >= 2 ? 32'h1 : 32'h0;
      tick();
    end
    s_tvalid = 1'b0;
    chk("abort_post_state", dbg_state, 3);
    abort_i = 1'b1;
    repeat (5) tick();
    chk("abort_flush_state", dbg_state, 4);
    s_tvalid = 1'b1;
    #1;
    chk("abort_tlast", {m_tvalid, m_tlast}, 2'b11);
    tick();
    s_tvalid = 1'b0;
    chk("abort_idle_state", dbg_state, 0);
    chk("abort_segments", segments_done_o, 0);
    abort_i = 1'b0;
    wait_idle(1'b1);

    // async reset mid-prebuffer
    configure(20, 2, 1, 32'h0, 32'h0, 32'h0);
    do_start();
    s_tvalid = 1'b1;
    repeat (3) tick();
    chk("midrst_pre_state", dbg_state, 1);
    stream_resetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_idle", idle_o, 1);
    chk("midrst_s_tready", s_tready, 1);
    s_tvalid = 1'b0;
    tick();
    stream_resetn = 1'b1;
    repeat (2) tick();

    m_prev = '0;
    for (int r = 0; r < 25; r++) begin
      r_pre = $urandom_range(0, 5);
      r_post = $urandom_range(0, 5);
      r_segs = $urandom_range(0, 3);
      r_en = $urandom_range(1, 15);
      r_inv = $urandom_range(0, 15);
      r_edg = $urandom_range(0, 15);
      configure(r_pre, r_post, r_segs, r_en, r_inv, r_edg);
      do_start();
      nseg = r_segs == 0 ? 1 : r_segs;
      seg = 0; idx = 0; tat = -1; c = 0; fresh = 1'b1;
      exp_det = '0; exp_tb = 0;
      while (seg < nseg && c < 600) begin
        if (fresh) begin
          d = $urandom;
          t = $urandom & 32'hF;
          fresh = 1'b0;
        end
        v = ($urandom % 4) != 0;
        rdy = ($urandom % 4) != 0;
        s_tvalid = v; s_tdata = d; trigger = t; m_tready = rdy;
        lvl = t ^ r_inv;
        hit = r_en & ((r_edg & lvl & ~m_prev) | (~r_edg & lvl));
        ntat = (tat < 0 && idx >= r_pre && hit != 0) ? idx : tat;
        last = ntat >= 0 && idx == ntat + r_post;
        #1;
        if (v) chk("rnd_beat", {m_tvalid, m_tlast, s_tready, m_tdata}, {1'b1, last, rdy, d});
        else chk("rnd_no_valid", m_tvalid, 0);
        tick();
        c++;
        if (v && rdy) begin
          m_prev = lvl;
          if (tat < 0 && ntat >= 0) begin
            exp_det = hit;
            exp_tb = idx;
          end
          tat = ntat;
          fresh = 1'b1;
          if (last) begin
            seg++;
            idx = 0;
            tat = -1;
          end else idx++;
        end
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      chk("rnd_completed", seg, nseg);
      wait_idle(1'b1);
      chk("rnd_segments", segments_done_o, nseg);
      chk("rnd_detected", trigger_detected_o, exp_det);
      chk("rnd_trigger_beat", trigger_beat_o, exp_tb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
